// File: rtl/cb_shreg_pkg.sv
// -----------------------------------------------------------------------------
// cb_shreg_pkg
// Shared constants for the parameterised shift register: the 3-bit operation
// encodings and a helper that classifies an operation as a shifting one
// (those are the operations that advance the shift counter).
// -----------------------------------------------------------------------------
package cb_shreg_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROTL  = 3'b100;
  localparam logic [2:0] MODE_ROTR  = 3'b101;
  localparam logic [2:0] MODE_ASHR  = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  // True for every operation that moves bits through the register.
  function automatic logic is_shift_mode(input logic [2:0] mode);
    logic res;
    case (mode)
      MODE_SHL, MODE_SHR, MODE_ROTL, MODE_ROTR, MODE_ASHR: res = 1'b1;
      default:                                             res = 1'b0;
    endcase
    return res;
  endfunction

  // True for the operations that restart the shift count.
  function automatic logic is_restart_mode(input logic [2:0] mode);
    logic res;
    case (mode)
      MODE_LOAD, MODE_CLEAR: res = 1'b1;
      default:               res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cb_sat_cnt.sv
// -----------------------------------------------------------------------------
// cb_sat_cnt
// Saturating shift counter with a one-cycle completion pulse.
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset (count 0, no pulse)
//   en_i     enable; when low the count holds and the pulse is 0
//   clr_i    restart the count at 0 (wins over inc_i)
//   inc_i    advance the count, saturating at MAX
//   cnt_o    current count, clog2(MAX+1) bits
//   done_o   1 for the single cycle in which the count has just reached MAX
// -----------------------------------------------------------------------------
module cb_sat_cnt #(
  parameter int MAX = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic                         clr_i,
  input  logic                         inc_i,
  output logic [$clog2(MAX+1)-1:0]     cnt_o,
  output logic                         done_o
);

  localparam int CW = $clog2(MAX + 1);
  localparam logic [CW-1:0] MAX_C    = CW'(MAX);
  localparam logic [CW-1:0] MAX_M1_C = CW'(MAX - 1);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  // Next count and pulse; the pulse only fires on the step into MAX, so a
  // saturated counter never re-fires and a restart suppresses it.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (en_i) begin
      if (clr_i) begin
        cnt_d = '0;
      end else if (inc_i) begin
        if (cnt_q != MAX_C) begin
          cnt_d  = cnt_q + ONE_C;
          done_d = (cnt_q == MAX_M1_C);
        end else begin
          cnt_d = cnt_q;
        end
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count and pulse registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign done_o = done_q;

endmodule

// File: rtl/cb_shift_reg_param.sv
// -----------------------------------------------------------------------------
// cb_shift_reg_param
// Parameterised multi-mode shift register (hold/load/shift/rotate/arith-shift/
// clear) with a saturating shift counter and completion pulse.
// Ports:
//   clk      clock, rising edge
//   rst      synchronous active-high reset: q=RST_VAL, cnt=0, done=0
//   en       operation enable; when low everything holds and done is 0
//   mode     operation select (see cb_shreg_pkg)
//   d        parallel load data
//   sin      serial input for SHL/SHR
//   q        registered contents
//   msb_out  q[WIDTH-1]
//   lsb_out  q[0]
//   cnt      shifts since the last LOAD/CLEAR, saturating at WIDTH
//   done     one-cycle pulse when cnt has just reached WIDTH
// -----------------------------------------------------------------------------
module cb_shift_reg_param
  import cb_shreg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [2:0]                   mode,
  input  logic [WIDTH-1:0]             d,
  input  logic                         sin,
  output logic [WIDTH-1:0]             q,
  output logic                         msb_out,
  output logic                         lsb_out,
  output logic [$clog2(WIDTH+1)-1:0]   cnt,
  output logic                         done
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             inc_s;
  logic             clr_s;

  // Next register value for the selected operation.
  always_comb begin
    q_d = q_q;
    if (en) begin
      case (mode)
        MODE_HOLD:  q_d = q_q;
        MODE_LOAD:  q_d = d;
        MODE_SHL:   q_d = {q_q[WIDTH-2:0], sin};
        MODE_SHR:   q_d = {sin, q_q[WIDTH-1:1]};
        MODE_ROTL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        MODE_ROTR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
        MODE_ASHR:  q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        MODE_CLEAR: q_d = RST_VAL;
        default:    q_d = q_q;
      endcase
    end else begin
      q_d = q_q;
    end
  end

  // Data register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign inc_s = is_shift_mode(mode);
  assign clr_s = is_restart_mode(mode);

  cb_sat_cnt #(
    .MAX (WIDTH)
  ) u_sat_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (en),
    .clr_i  (clr_s),
    .inc_i  (inc_s),
    .cnt_o  (cnt),
    .done_o (done)
  );

  assign q       = q_q;
  assign msb_out = q_q[WIDTH-1];
  assign lsb_out = q_q[0];

endmodule

// File: tb/tb_cb_shift_reg_param.sv
// Self-checking bench for cb_shift_reg_param (WIDTH=8, RST_VAL=8'hA5).
module tb_cb_shift_reg_param;

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_ROTL  = 3'b100;
  localparam logic [2:0] M_ROTR  = 3'b101;
  localparam logic [2:0] M_ASHR  = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;
  localparam logic [7:0] RV      = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [7:0] d = 8'h00;
  logic       sin = 1'b0;
  logic [7:0] q;
  logic       msb_out;
  logic       lsb_out;
  logic [3:0] cnt;
  logic       done;

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] cnt;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // reference state
  logic [7:0] mq = 8'h00;
  logic [3:0] mc = 4'd0;
  logic       md = 1'b0;

  cb_shift_reg_param #(.WIDTH(8), .RST_VAL(8'hA5)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin(sin),
    .q(q), .msb_out(msb_out), .lsb_out(lsb_out), .cnt(cnt), .done(done)
  );

  always #5 clk = ~clk;

  // Advance the reference model by one clock edge and queue its outputs.
  task automatic model(input bit r, input bit e, input logic [2:0] m,
                       input logic [7:0] dv, input bit s);
    if (r) begin
      mq = RV; mc = 4'd0; md = 1'b0;
    end else if (!e) begin
      md = 1'b0;
    end else begin
      md = 1'b0;
      case (m)
        M_LOAD:  begin mq = dv; mc = 4'd0; end
        M_CLEAR: begin mq = RV; mc = 4'd0; end
        M_SHL:   mq = {mq[6:0], s};
        M_SHR:   mq = {s, mq[7:1]};
        M_ROTL:  mq = {mq[6:0], mq[7]};
        M_ROTR:  mq = {mq[0], mq[7:1]};
        M_ASHR:  mq = {mq[7], mq[7:1]};
        default: mq = mq;
      endcase
      if (m >= M_SHL && m <= M_ASHR) begin
        if (mc == 4'd7) md = 1'b1;
        if (mc < 4'd8) mc = mc + 4'd1;
      end
    end
    sb.push_back('{q: mq, cnt: mc, done: md});
  endtask

  // Apply one cycle of stimulus; outputs are then sampled 1 time unit after the edge.
  task automatic drive(input bit r, input bit e, input logic [2:0] m,
                       input logic [7:0] dv, input bit s);
    rst = r; en = e; mode = m; d = dv; sin = s;
    model(r, e, m, dv, s);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t ex;
    drive(1'b1, 1'b1, M_LOAD, 8'hFF, 1'b0);
    ex = sb.pop_front();
    checks++;
    if ({q, cnt, done} !== {ex.q, ex.cnt, ex.done}) begin
      failures++;
      $display("FAIL reset_sb got q=%h cnt=%0d done=%0b exp q=%h cnt=%0d done=%0b", q, cnt, done, ex.q, ex.cnt, ex.done);
    end
    checks++;
    if (q !== 8'hA5 || cnt !== 4'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_val got q=%h cnt=%0d done=%0b exp q=a5 cnt=0 done=0", q, cnt, done);
    end
  endtask

  task automatic test_load_shl();
    exp_t ex;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive(1'b0, 1'b1, M_LOAD, 8'h81, 1'b0);
      else        drive(1'b0, 1'b1, M_SHL, 8'h00, 1'b1);
      ex = sb.pop_front();
      checks++;
      if ({q, cnt, done, msb_out, lsb_out} !== {ex.q, ex.cnt, ex.done, ex.q[7], ex.q[0]}) begin
        failures++;
        $display("FAIL load_shl step%0d got q=%h cnt=%0d done=%0b exp q=%h cnt=%0d done=%0b", i, q, cnt, done, ex.q, ex.cnt, ex.done);
      end
    end
    checks++;
    if (q !== 8'h03 || cnt !== 4'd1 || msb_out !== 1'b0 || lsb_out !== 1'b1) begin
      failures++;
      $display("FAIL load_shl_val got q=%h cnt=%0d msb=%0b lsb=%0b exp q=03 cnt=1 msb=0 lsb=1", q, cnt, msb_out, lsb_out);
    end
  endtask

  task automatic test_rotate_full();
    exp_t ex;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) drive(1'b0, 1'b1, M_LOAD, 8'h96, 1'b0);
      else        drive(1'b0, 1'b1, M_ROTR, 8'h00, 1'($urandom_range(0, 1)));
      ex = sb.pop_front();
      checks++;
      if ({q, cnt, done} !== {ex.q, ex.cnt, ex.done}) begin
        failures++;
        $display("FAIL rotr step%0d got q=%h cnt=%0d done=%0b exp q=%h cnt=%0d done=%0b", i, q, cnt, done, ex.q, ex.cnt, ex.done);
      end
      if (i == 8) begin
        checks++;
        if (q !== 8'h96 || cnt !== 4'd8 || done !== 1'b1) begin
          failures++;
          $display("FAIL rotr_turn got q=%h cnt=%0d done=%0b exp q=96 cnt=8 done=1", q, cnt, done);
        end
      end
      if (i == 9) begin
        checks++;
        if (cnt !== 4'd8 || done !== 1'b0) begin
          failures++;
          $display("FAIL rotr_sat got cnt=%0d done=%0b exp cnt=8 done=0", cnt, done);
        end
      end
    end
  endtask

  task automatic test_ashr_hold();
    exp_t ex;
    for (int i = 0; i < 6; i++) begin
      if (i == 0)     drive(1'b0, 1'b1, M_LOAD, 8'h80, 1'b0);
      else if (i < 4) drive(1'b0, 1'b1, M_ASHR, 8'h00, 1'b0);
      else            drive(1'b0, 1'b0, M_LOAD, 8'h5A, 1'b1);
      ex = sb.pop_front();
      checks++;
      if ({q, cnt, done} !== {ex.q, ex.cnt, ex.done}) begin
        failures++;
        $display("FAIL ashr step%0d got q=%h cnt=%0d done=%0b exp q=%h cnt=%0d done=%0b", i, q, cnt, done, ex.q, ex.cnt, ex.done);
      end
    end
    checks++;
    if (q !== 8'hF0 || cnt !== 4'd3) begin
      failures++;
      $display("FAIL ashr_hold_val got q=%h cnt=%0d exp q=f0 cnt=3", q, cnt);
    end
  endtask

  task automatic test_reset_mid();
    exp_t ex;
    for (int i = 0; i < 7; i++) begin
      if (i == 0)      drive(1'b0, 1'b1, M_LOAD, 8'h3C, 1'b0);
      else if (i < 5)  drive(1'b0, 1'b1, M_SHL, 8'h00, 1'b0);
      else if (i == 5) drive(1'b1, 1'b1, M_SHL, 8'h00, 1'b0);
      else             drive(1'b0, 1'b1, M_SHL, 8'h00, 1'b1);
      ex = sb.pop_front();
      checks++;
      if ({q, cnt, done} !== {ex.q, ex.cnt, ex.done}) begin
        failures++;
        $display("FAIL rst_mid step%0d got q=%h cnt=%0d done=%0b exp q=%h cnt=%0d done=%0b", i, q, cnt, done, ex.q, ex.cnt, ex.done);
      end
      if (i == 5) begin
        checks++;
        if (q !== 8'hA5 || cnt !== 4'd0 || done !== 1'b0) begin
          failures++;
          $display("FAIL rst_mid_val got q=%h cnt=%0d done=%0b exp q=a5 cnt=0 done=0", q, cnt, done);
        end
      end
    end
    checks++;
    if (q !== 8'h4B || cnt !== 4'd1) begin
      failures++;
      $display("FAIL post_rst_shl got q=%h cnt=%0d exp q=4b cnt=1", q, cnt);
    end
  endtask

  task automatic test_priority_clear();
    exp_t ex;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      drive(1'b0, 1'b1, M_LOAD, 8'h00, 1'b0);
      else if (i < 8)  drive(1'b0, 1'b1, M_SHL, 8'h00, 1'($urandom_range(0, 1)));
      else if (i == 8) drive(1'b0, 1'b1, M_LOAD, 8'h11, 1'b0);
      else             drive(1'b0, 1'b1, M_CLEAR, 8'hFF, 1'b1);
      ex = sb.pop_front();
      checks++;
      if ({q, cnt, done} !== {ex.q, ex.cnt, ex.done}) begin
        failures++;
        $display("FAIL prio step%0d got q=%h cnt=%0d done=%0b exp q=%h cnt=%0d done=%0b", i, q, cnt, done, ex.q, ex.cnt, ex.done);
      end
      if (i == 7) begin
        checks++;
        if (cnt !== 4'd7) begin
          failures++;
          $display("FAIL prio_cnt7 got cnt=%0d exp 7", cnt);
        end
      end
      if (i == 8) begin
        checks++;
        if (q !== 8'h11 || cnt !== 4'd0 || done !== 1'b0) begin
          failures++;
          $display("FAIL prio_load got q=%h cnt=%0d done=%0b exp q=11 cnt=0 done=0", q, cnt, done);
        end
      end
    end
    checks++;
    if (q !== 8'hA5 || cnt !== 4'd0) begin
      failures++;
      $display("FAIL clear_val got q=%h cnt=%0d exp q=a5 cnt=0", q, cnt);
    end
  endtask

  task automatic test_back_to_back();
    exp_t ex;
    for (int i = 0; i < 200; i++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0),
            3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)));
      ex = sb.pop_front();
      checks++;
      if ({q, cnt, done, msb_out, lsb_out} !== {ex.q, ex.cnt, ex.done, ex.q[7], ex.q[0]}) begin
        failures++;
        $display("FAIL random step%0d got q=%h cnt=%0d done=%0b exp q=%h cnt=%0d done=%0b", i, q, cnt, done, ex.q, ex.cnt, ex.done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_shl();
    test_rotate_full();
    test_ashr_hold();
    test_reset_mid();
    test_priority_clear();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cb_shift_reg_param.md
CB_SHIFT_REG_PARAM -- requirements
Module: cb_shift_reg_param

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, meaning register width in bits; legal range is 2 to 64.
REQ-002 The block SHALL provide parameter RST_VAL, default 0, meaning the WIDTH-bit value loaded into q on reset and on the CLEAR mode.
REQ-003 clk  input  1  sole clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  operation enable; when low, all state holds.
REQ-006 mode  input  3  operation select, decoded per REQ-012.
REQ-007 d  input  WIDTH  parallel load data.
REQ-008 sin  input  1  serial input for the shift modes.
REQ-009 q  output  WIDTH  register contents.
REQ-010 msb_out / lsb_out  output  1 each  q[WIDTH-1] and q[0], driven combinationally from q.
REQ-011 cnt  output  clog2(WIDTH+1)  shift count since the last LOAD/CLEAR; done  output  1  one-cycle completion pulse.

Function
REQ-012 mode encoding SHALL be: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROTL, 101 ROTR, 110 ASHR, 111 CLEAR.
REQ-013 HOLD SHALL keep q; LOAD SHALL set q=d; CLEAR SHALL set q=RST_VAL.
REQ-014 SHL SHALL set q={q[WIDTH-2:0],sin}; SHR SHALL set q={sin,q[WIDTH-1:1]}.
REQ-015 ROTL SHALL set q={q[WIDTH-2:0],q[WIDTH-1]}; ROTR SHALL set q={q[0],q[WIDTH-1:1]}; sin SHALL be ignored in both.
REQ-016 ASHR SHALL set q={q[WIDTH-1],q[WIDTH-1:1]}; sin SHALL be ignored.
REQ-017 Every q update SHALL take effect one cycle after the qualifying edge, with no combinational path from d or sin to q.
REQ-018 When en=0, q, cnt and done SHALL hold, except that done SHALL be 0.
REQ-019 LOAD and CLEAR with en=1 SHALL set cnt=0.
REQ-020 SHL, SHR, ROTL, ROTR and ASHR with en=1 SHALL increment cnt, saturating at WIDTH.
REQ-021 HOLD SHALL leave cnt unchanged.
REQ-022 done SHALL be 1 for exactly the cycle after cnt moves from WIDTH-1 to WIDTH, and 0 otherwise.
REQ-023 No done pulse SHALL be produced while cnt is saturated.
REQ-024 A LOAD in the same cycle as saturation SHALL take priority: cnt=0 and done=0.

Reset
REQ-025 On rst=1 at a clock edge, the block SHALL set q=RST_VAL, cnt=0 and done=0, regardless of en or mode.
REQ-026 rst SHALL override any operation in progress, including a shift mid-count; the next cycle SHALL show the reset values.
REQ-027 After rst deasserts, the first en=1 edge SHALL execute the selected mode normally.

Structure
REQ-028 Mode encodings, as named localparam constants, SHALL reside in shared package cb_shreg_pkg.
REQ-029 The saturating counter and done-pulse logic SHALL be one sub-module, cb_sat_cnt, parameterised by its MAX count (WIDTH).
REQ-030 The block SHALL be fully synchronous, with no latches and no asynchronous reset.

Verification (WIDTH=8, RST_VAL=8'hA5 unless stated)
REQ-031 Reset: rst=1 for one edge with mode=LOAD, d=8'hFF -> q=8'hA5, cnt=0, done=0.
REQ-032 Load then SHL: LOAD d=8'h81, then SHL x1 with sin=1 -> q=8'h03, cnt=1, msb_out=0, lsb_out=1.
REQ-033 Rotate full turn: LOAD 8'h96, then ROTR x8 -> q=8'h96 again, cnt=8, done high only on the cycle after the 8th shift; a 9th ROTR -> cnt stays 8, done=0.
REQ-034 ASHR sign fill: LOAD 8'h80, then ASHR x3 -> q=8'hF0; en=0 for 2 cycles -> q and cnt unchanged.
REQ-035 Reset mid-operation: LOAD 8'h3C, SHL x4 with sin=0, then rst=1 -> q=8'hA5, cnt=0, and no done pulse.
REQ-036 Priority and CLEAR: reach cnt=7, then LOAD 8'h11 -> cnt=0, done=0, q=8'h11; then CLEAR -> q=8'hA5.
